// File: rtl/alu_arbiter_if.sv
// Bus bundle between the issue-side requesters, the arbiter and the shared ALU.
// slave is the arbiter's view; master is the environment's view (requesters and ALU).
interface alu_arbiter_if;
  // requester 0
  logic         req0_valid;
  logic         req0_ready;
  logic [2:0]   req0_op;
  logic         req0_form;
  logic [1:0]   req0_vec;
  logic [4:0]   req0_copy;
  logic [127:0] req0_opnd;
  // requester 1
  logic         req1_valid;
  logic         req1_ready;
  logic [2:0]   req1_op;
  logic         req1_form;
  logic [1:0]   req1_vec;
  logic [4:0]   req1_copy;
  logic [127:0] req1_opnd;
  // ALU input bus and results
  logic [2:0]   alu_op;
  logic         alu_form;
  logic [1:0]   alu_vec;
  logic [31:0]  alu_a;
  logic [31:0]  alu_b;
  logic [31:0]  alu_c;
  logic [31:0]  alu_d;
  logic         alu_copy_neg;
  logic [3:0]   alu_copy_select;
  logic [31:0]  alu_y1;
  logic [31:0]  alu_y2;
  // response channels (data shared by both)
  logic         rsp0_valid;
  logic         rsp0_ready;
  logic         rsp1_valid;
  logic         rsp1_ready;
  logic [31:0]  rsp_y1;
  logic [31:0]  rsp_y2;
  logic         rsp_err;
  logic         busy;

  modport slave (
    input  req0_valid, req0_op, req0_form, req0_vec, req0_copy, req0_opnd,
    input  req1_valid, req1_op, req1_form, req1_vec, req1_copy, req1_opnd,
    output req0_ready, req1_ready,
    output alu_op, alu_form, alu_vec, alu_a, alu_b, alu_c, alu_d,
    output alu_copy_neg, alu_copy_select,
    input  alu_y1, alu_y2,
    output rsp0_valid, rsp1_valid, rsp_y1, rsp_y2, rsp_err, busy,
    input  rsp0_ready, rsp1_ready
  );

  modport master (
    output req0_valid, req0_op, req0_form, req0_vec, req0_copy, req0_opnd,
    output req1_valid, req1_op, req1_form, req1_vec, req1_copy, req1_opnd,
    input  req0_ready, req1_ready,
    input  alu_op, alu_form, alu_vec, alu_a, alu_b, alu_c, alu_d,
    input  alu_copy_neg, alu_copy_select,
    output alu_y1, alu_y2,
    input  rsp0_valid, rsp1_valid, rsp_y1, rsp_y2, rsp_err, busy,
    output rsp0_ready, rsp1_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One op in flight: operands are registered onto the ALU bus, held for EXEC_LAT
// cycles, then Y1/Y2 are captured and returned to the owner over valid/ready.
module alu_arbiter #(
  parameter int unsigned EXEC_LAT = 1  // legal 1..15
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_COPY = 3'b010;
  localparam logic [3:0] CNT_INIT = 4'(EXEC_LAT - 1);

  state_t       state, state_next;
  logic         last_gnt;   // requester granted most recently; 1 after reset so req0 leads
  logic         owner;      // requester owning the in-flight op
  logic [3:0]   cnt;

  logic         gnt_valid;
  logic         gnt_id;
  logic         accept;
  logic         op_legal;
  logic         rsp_done;
  logic [2:0]   sel_op;
  logic         sel_form;
  logic [1:0]   sel_vec;
  logic [4:0]   sel_copy;
  logic [127:0] sel_opnd;

  // Grant: a lone requester wins; on contention the one not granted last wins.
  // NOTE: every signal assigned in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    gnt_valid = bus.req0_valid | bus.req1_valid;
    gnt_id    = 1'b0;
    if (bus.req0_valid && bus.req1_valid) gnt_id = ~last_gnt;
    else if (bus.req1_valid)              gnt_id = 1'b1;
    sel_op   = gnt_id ? bus.req1_op   : bus.req0_op;
    sel_form = gnt_id ? bus.req1_form : bus.req0_form;
    sel_vec  = gnt_id ? bus.req1_vec  : bus.req0_vec;
    sel_copy = gnt_id ? bus.req1_copy : bus.req0_copy;
    sel_opnd = gnt_id ? bus.req1_opnd : bus.req0_opnd;
  end

  assign accept   = (state == IDLE) && gnt_valid;
  assign op_legal = (sel_op == OP_ADD) || (sel_op == OP_SUB) || (sel_op == OP_COPY);
  assign rsp_done = (state == RESP) && (owner ? bus.rsp1_ready : bus.rsp0_ready);

  assign bus.req0_ready = accept && !gnt_id;
  assign bus.req1_ready = accept &&  gnt_id;
  assign bus.rsp0_valid = (state == RESP) && !owner;
  assign bus.rsp1_valid = (state == RESP) &&  owner;
  assign bus.busy       = (state != IDLE);

  // Next-state logic; completing a response always returns through IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = op_legal ? EXEC : RESP;
      EXEC: if (cnt == 4'd0) state_next = RESP;
      RESP: if (rsp_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Datapath: latch the winner onto the ALU bus, count the hold time, capture results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt            <= 1'b1;
      owner               <= 1'b0;
      cnt                 <= 4'd0;
      bus.alu_op          <= '0;
      bus.alu_form        <= 1'b0;
      bus.alu_vec         <= '0;
      bus.alu_copy_neg    <= 1'b0;
      bus.alu_copy_select <= '0;
      bus.alu_a           <= '0;
      bus.alu_b           <= '0;
      bus.alu_c           <= '0;
      bus.alu_d           <= '0;
      bus.rsp_y1          <= '0;
      bus.rsp_y2          <= '0;
      bus.rsp_err         <= 1'b0;
    end else begin
      if (accept) begin
        owner               <= gnt_id;
        last_gnt            <= gnt_id;
        bus.alu_op          <= sel_op;
        bus.alu_form        <= sel_form;
        bus.alu_vec         <= sel_vec;
        bus.alu_copy_neg    <= sel_copy[4];
        bus.alu_copy_select <= sel_copy[3:0];
        {bus.alu_a, bus.alu_b, bus.alu_c, bus.alu_d} <= sel_opnd;
        if (op_legal) begin
          cnt <= CNT_INIT;
        end else begin
          // Unsupported op: answer straight away with an error and zero data.
          cnt         <= 4'd0;
          bus.rsp_y1  <= '0;
          bus.rsp_y2  <= '0;
          bus.rsp_err <= 1'b1;
        end
      end else if (state == EXEC) begin
        if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else begin
          bus.rsp_y1  <= bus.alu_y1;
          bus.rsp_y2  <= bus.alu_y2;
          bus.rsp_err <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance with EXEC_LAT=1 for the functional
// sequence, one with EXEC_LAT=4 for the long-latency and mid-op reset cases.
// A small ALU model drives alu_y1/alu_y2: ADD y1=A+C y2=B+D, SUB y1=A-C y2=B-D, COPY y1=A y2=B.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_arbiter_if bus1 ();
  alu_arbiter_if bus4 ();

  alu_arbiter #(.EXEC_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  alu_arbiter #(.EXEC_LAT(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

  function automatic logic [63:0] alu_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] c,
                                            input logic [31:0] d);
    case (op)
      3'b000:  return {a + c, b + d};
      3'b100:  return {a - c, b - d};
      3'b010:  return {a, b};
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  assign {bus1.alu_y1, bus1.alu_y2} = alu_model(bus1.alu_op, bus1.alu_a, bus1.alu_b, bus1.alu_c, bus1.alu_d);
  assign {bus4.alu_y1, bus4.alu_y2} = alu_model(bus4.alu_op, bus4.alu_a, bus4.alu_b, bus4.alu_c, bus4.alu_d);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock, then step off the edge before driving or sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_inputs();
    bus1.req0_valid = 0; bus1.req0_op = 0; bus1.req0_form = 0; bus1.req0_vec = 0;
    bus1.req0_copy = 0;  bus1.req0_opnd = 0;
    bus1.req1_valid = 0; bus1.req1_op = 0; bus1.req1_form = 0; bus1.req1_vec = 0;
    bus1.req1_copy = 0;  bus1.req1_opnd = 0;
    bus1.rsp0_ready = 0; bus1.rsp1_ready = 0;
    bus4.req0_valid = 0; bus4.req0_op = 0; bus4.req0_form = 0; bus4.req0_vec = 0;
    bus4.req0_copy = 0;  bus4.req0_opnd = 0;
    bus4.req1_valid = 0; bus4.req1_op = 0; bus4.req1_form = 0; bus4.req1_vec = 0;
    bus4.req1_copy = 0;  bus4.req1_opnd = 0;
    bus4.rsp0_ready = 0; bus4.rsp1_ready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_w;
    init_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // ---- reset then idle for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_busy",  {63'd0, bus1.busy}, 64'd0);
      check("idle_ready", {62'd0, bus1.req0_ready, bus1.req1_ready}, 64'd0);
      check("idle_rsp",   {bus1.rsp_y1, bus1.rsp_y2}, 64'd0);
      check("idle_rspv",  {61'd0, bus1.rsp0_valid, bus1.rsp1_valid, bus1.rsp_err}, 64'd0);
      check("idle_alu_ab", {bus1.alu_a, bus1.alu_b}, 64'd0);
      check("idle_alu_cd", {bus1.alu_c, bus1.alu_d}, 64'd0);
      check("idle_alu_ctl", {53'd0, bus1.alu_op, bus1.alu_form, bus1.alu_vec,
                             bus1.alu_copy_neg, bus1.alu_copy_select}, 64'd0);
    end
    check("idle_busy4", {63'd0, bus4.busy}, 64'd0);

    // ---- single ADD, EXEC_LAT=1
    bus1.req0_valid = 1; bus1.req0_op = 3'b000; bus1.req0_vec = 2'b10; bus1.req0_form = 0;
    bus1.req0_opnd = {32'd5, 32'd7, 32'd3, 32'd1}; bus1.rsp0_ready = 1;
    #1;
    check("add_ready", {62'd0, bus1.req0_ready, bus1.req1_ready}, 64'b10);
    tick();  // accept edge
    bus1.req0_valid = 0;
    #1;
    check("add_exec_busy",  {63'd0, bus1.busy}, 64'd1);
    check("add_exec_ready", {63'd0, bus1.req0_ready}, 64'd0);
    check("add_exec_nrsp",  {62'd0, bus1.rsp0_valid, bus1.rsp1_valid}, 64'd0);
    check("add_alu_ab", {bus1.alu_a, bus1.alu_b}, {32'd5, 32'd7});
    check("add_alu_cd", {bus1.alu_c, bus1.alu_d}, {32'd3, 32'd1});
    check("add_alu_vec", {62'd0, bus1.alu_vec}, 64'd2);
    tick();
    check("add_rsp_v", {61'd0, bus1.rsp0_valid, bus1.rsp1_valid, bus1.rsp_err}, 64'b100);
    check("add_rsp_y", {bus1.rsp_y1, bus1.rsp_y2}, {32'd8, 32'd8});
    tick();
    check("add_done", {62'd0, bus1.busy, bus1.rsp0_valid}, 64'd0);

    // ---- contention: req0 was granted last, so the order is 1,0,1,0
    bus1.req0_valid = 1; bus1.req0_op = 3'b000; bus1.req0_opnd = {32'd20, 32'd2, 32'd5, 32'd1};
    bus1.req1_valid = 1; bus1.req1_op = 3'b100; bus1.req1_opnd = {32'd100, 32'd50, 32'd1, 32'd7};
    bus1.rsp0_ready = 1; bus1.rsp1_ready = 1;
    #1;
    exp_w = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("rr_grant", {62'd0, bus1.req0_ready, bus1.req1_ready}, exp_w ? 64'b01 : 64'b10);
      tick();
      tick();
      check("rr_rsp_valid", {62'd0, bus1.rsp0_valid, bus1.rsp1_valid}, exp_w ? 64'b01 : 64'b10);
      check("rr_rsp_data", {bus1.rsp_y1, bus1.rsp_y2},
            exp_w ? {32'd99, 32'd43} : {32'd25, 32'd3});
      tick();
      exp_w = ~exp_w;
    end

    // ---- backpressure: req1 SUB held in RESP for 6 cycles, req0 waiting
    bus1.req1_op = 3'b100; bus1.req1_opnd = {32'd10, 32'd0, 32'd4, 32'd0};
    bus1.rsp1_ready = 0; bus1.rsp0_ready = 1;
    #1;
    check("bp_grant", {62'd0, bus1.req0_ready, bus1.req1_ready}, 64'b01);
    tick();
    bus1.req1_valid = 0;
    #1;
    tick();
    for (int i = 0; i < 6; i++) begin
      check("bp_valid", {62'd0, bus1.rsp0_valid, bus1.rsp1_valid}, 64'b01);
      check("bp_y", {bus1.rsp_y1, bus1.rsp_y2}, {32'd6, 32'd0});
      check("bp_alu", {bus1.alu_a, bus1.alu_c}, {32'd10, 32'd4});
      check("bp_no_ready0", {63'd0, bus1.req0_ready}, 64'd0);
      tick();
    end
    bus1.rsp1_ready = 1;
    tick();
    check("bp_idle", {62'd0, bus1.busy, bus1.rsp1_valid}, 64'd0);
    check("bp_ready0", {62'd0, bus1.req0_ready, bus1.req1_ready}, 64'b10);
    tick();
    bus1.req0_valid = 0;
    #1;
    check("bp_acc0", {bus1.alu_a, 31'd0, bus1.busy}, {32'd20, 32'd1});
    tick();
    check("bp_rsp0", {bus1.rsp_y1, bus1.rsp_y2}, {32'd25, 32'd3});
    check("bp_rsp0_v", {62'd0, bus1.rsp0_valid, bus1.rsp1_valid}, 64'b10);
    tick();

    // ---- illegal op: response one cycle after accept, error flagged, zero data
    bus1.req0_valid = 1; bus1.req0_op = 3'b111; bus1.req0_opnd = {32'd1, 32'd2, 32'd3, 32'd4};
    bus1.rsp0_ready = 0;
    #1;
    check("ill_ready", {62'd0, bus1.req0_ready, bus1.req1_ready}, 64'b10);
    tick();
    bus1.req0_valid = 0;
    #1;
    check("ill_rsp_v", {61'd0, bus1.rsp0_valid, bus1.rsp1_valid, bus1.rsp_err}, 64'b101);
    check("ill_rsp_y", {bus1.rsp_y1, bus1.rsp_y2}, 64'd0);
    bus1.rsp0_ready = 1;
    tick();
    check("ill_done", {63'd0, bus1.busy}, 64'd0);

    // ---- COPY on req1: control fields pass through, error clears
    bus1.req1_valid = 1; bus1.req1_op = 3'b010; bus1.req1_form = 1; bus1.req1_copy = 5'b10011;
    bus1.req1_opnd = {32'hDEAD_BEEF, 32'h0000_1234, 32'd0, 32'd0}; bus1.rsp1_ready = 1;
    #1;
    tick();
    bus1.req1_valid = 0;
    #1;
    check("copy_ctl", {58'd0, bus1.alu_form, bus1.alu_copy_neg, bus1.alu_copy_select}, 64'b110011);
    tick();
    check("copy_rsp_v", {61'd0, bus1.rsp0_valid, bus1.rsp1_valid, bus1.rsp_err}, 64'b010);
    check("copy_rsp_y", {bus1.rsp_y1, bus1.rsp_y2}, {32'hDEAD_BEEF, 32'h0000_1234});
    tick();

    // ---- EXEC_LAT=4: reset two cycles after accept, between clock edges
    bus4.req0_valid = 1; bus4.req0_op = 3'b000; bus4.req0_opnd = {32'd1, 32'd2, 32'd3, 32'd4};
    bus4.rsp0_ready = 1;
    #1;
    check("r4_ready", {62'd0, bus4.req0_ready, bus4.req1_ready}, 64'b10);
    tick();
    bus4.req0_valid = 0;
    #1;
    check("r4_busy", {63'd0, bus4.busy}, 64'd1);
    check("r4_alu", {bus4.alu_a, bus4.alu_b}, {32'd1, 32'd2});
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("r4_clr_busy", {63'd0, bus4.busy}, 64'd0);
    check("r4_clr_alu", {bus4.alu_a, bus4.alu_b}, 64'd0);
    check("r4_clr_ctl", {58'd0, bus4.alu_op, bus4.alu_vec, bus4.rsp_err}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("r4_no_rsp", {61'd0, bus4.rsp0_valid, bus4.rsp1_valid, bus4.busy}, 64'd0);
    end
    // pointer back to req0 priority
    bus4.req0_valid = 1; bus4.req0_op = 3'b000; bus4.req0_opnd = {32'd1, 32'd2, 32'd3, 32'd4};
    bus4.req1_valid = 1; bus4.req1_op = 3'b000; bus4.req1_opnd = {32'd9, 32'd9, 32'd9, 32'd9};
    #1;
    check("r4_prio", {62'd0, bus4.req0_ready, bus4.req1_ready}, 64'b10);
    tick();
    bus4.req0_valid = 0; bus4.req1_valid = 0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("r4_lat_wait", {62'd0, bus4.rsp0_valid, bus4.rsp1_valid}, 64'd0);
      tick();
    end
    check("r4_lat_v", {61'd0, bus4.rsp0_valid, bus4.rsp1_valid, bus4.rsp_err}, 64'b100);
    check("r4_lat_y", {bus4.rsp_y1, bus4.rsp_y2}, {32'd4, 32'd6});
    tick();
    check("r4_done", {63'd0, bus4.busy}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
